// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// State encoding is fixed at 2 bits; code 3 is unused and recovers to idle.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic ReqCpu = 1'b0;
  localparam logic ReqAux = 1'b1;

  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultDw = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the memory-port arbiter.
// The slave modport is the arbiter's view; master is its environment.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = mem_port_arbiter_pkg::DefaultAw,
  parameter int unsigned DW = mem_port_arbiter_pkg::DefaultDw
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          grant_id;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, grant_id
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, grant_id
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = ReqCpu;
    case (req)
      2'b01:   grant = ReqCpu;
      2'b10:   grant = ReqAux;
      2'b11:   grant = ~last;
      default: grant = ReqCpu;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to one of two requesters, holds the access
// for MEM_LAT cycles, then returns a one-cycle ack with captured read data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            grant_q, last_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;

  logic arb_grant, arb_valid;
  logic load, capture, access, resp;

  mem_port_arbiter_rr_arb2 u_rr_arb2 (
    .req   ({bus.m1_req, bus.m0_req}),
    .last  (last_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          load    = 1'b1;
          cnt_d   = CntW'(MEM_LAT - 1);
          state_d = StAccess;
        end
      end
      StAccess: begin
        access = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        resp    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= ReqCpu;
      last_q   <= ReqAux;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        we_q    <= arb_grant ? bus.m1_we    : bus.m0_we;
        addr_q  <= arb_grant ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= arb_grant ? bus.m1_wdata : bus.m0_wdata;
        grant_q <= arb_grant;
        last_q  <= arb_grant;
      end
      // Writes leave the requester's read-data register untouched.
      if (capture && !we_q) begin
        if (grant_q == ReqAux) rdata1_q <= bus.mem_rdata;
        else                   rdata0_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = access;
  assign bus.mem_we    = access & we_q;
  assign bus.mem_addr  = access ? addr_q  : '0;
  assign bus.mem_wdata = access ? wdata_q : '0;
  assign bus.m0_ack    = resp & (grant_q == ReqCpu);
  assign bus.m1_ack    = resp & (grant_q == ReqAux);
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.busy      = access | resp;
  assign bus.grant_id  = grant_q;

endmodule
